ram_io_responder: RTL and testbench



---
 rtl/ram_io_responder.sv | 119 +++++++++++
 tb/tb_ram_io_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_io_responder.sv
// RAM-side responder for the RAM_IO tile: services FAB2RAM commands against an
// internal synchronous 16-bit memory and returns read data on RAM2FAB.
// Optional burst addressing is compiled in with `define RAM_IO_RESPONDER_BURST_EN.
module ram_io_responder #(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic        UserCLK,
    input  logic        Reset,
    input  logic [15:0] FAB2RAM_D,
    input  logic [7:0]  FAB2RAM_A,
    input  logic [3:0]  FAB2RAM_C,
    output logic [15:0] RAM2FAB_D,
    output logic        rd_valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          ce, we_en, rd_en;
    logic [7:0]    eaddr;
    logic [AW-1:0] idx;
    logic [15:0]   mem [0:DEPTH-1];
    logic [15:0]   rdata;
    logic [15:0]   dout_q;
    logic          vld_q;

    // CE gates everything, so X on WE/RE/A/D while idle cannot reach state
    assign ce    = FAB2RAM_C[2];
    assign we_en = ce & FAB2RAM_C[0];
    assign rd_en = ce & FAB2RAM_C[1];

    // Addresses beyond DEPTH alias back into the array
    assign idx   = AW'(32'(eaddr) % 32'(DEPTH));
    assign rdata = mem[idx];

`ifdef RAM_IO_RESPONDER_BURST_EN
    logic       burst;
    logic       bact_q, bact_d;
    logic [7:0] cnt_q, cnt_d;

    assign burst = ce & FAB2RAM_C[3];

    // Burst address selection and counter next-state
    always_comb begin
        eaddr  = FAB2RAM_A;
        bact_d = 1'b0;
        cnt_d  = cnt_q;
        if (burst) begin
            bact_d = 1'b1;
            if (bact_q) eaddr = cnt_q;
            // A burst start with no access just loads the counter
            if (FAB2RAM_C[0] | FAB2RAM_C[1])
                cnt_d = (32'(idx) == DEPTH - 1) ? 8'd0 : 8'(idx) + 8'd1;
            else
                cnt_d = eaddr;
        end
    end

    // Burst counter and active flag
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            cnt_q  <= 8'd0;
            bact_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bact_q <= bact_d;
        end
    end
`else
    logic unused_burst;
    assign unused_burst = FAB2RAM_C[3];
    assign eaddr        = FAB2RAM_A;
`endif

    // Memory write port; contents deliberately not reset
    always_ff @(posedge UserCLK) begin
        if (we_en) mem[idx] <= FAB2RAM_D;
    end

    if (DEPTH < 1 || DEPTH > 256) begin : g_bad_depth
        $error("ram_io_responder: DEPTH must be 1..256");
    end

    if (READ_LATENCY == 1) begin : g_lat1
        // Single stage: read data straight into the output register
        always_ff @(posedge UserCLK or posedge Reset) begin
            if (Reset) begin
                dout_q <= 16'h0000;
                vld_q  <= 1'b0;
            end else begin
                vld_q <= rd_en;
                if (rd_en) dout_q <= rdata;
            end
        end
    end else if (READ_LATENCY == 2) begin : g_lat2
        logic [15:0] s1_d_q;
        logic        s1_v_q;
        // Two stages: old data captured at sample edge, presented one edge later
        always_ff @(posedge UserCLK or posedge Reset) begin
            if (Reset) begin
                s1_d_q <= 16'h0000;
                s1_v_q <= 1'b0;
                dout_q <= 16'h0000;
                vld_q  <= 1'b0;
            end else begin
                s1_v_q <= rd_en;
                if (rd_en) s1_d_q <= rdata;
                vld_q <= s1_v_q;
                if (s1_v_q) dout_q <= s1_d_q;
            end
        end
    end else begin : g_bad_lat
        $error("ram_io_responder: READ_LATENCY must be 1 or 2");
    end

    assign RAM2FAB_D = dout_q;
    assign rd_valid  = vld_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Bench for ram_io_responder: latency-1 and latency-2 instances share one
// stimulus stream and are compared against a word-level behavioural model.
module tb_ram_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fd;
    logic [7:0]  fa;
    logic [3:0]  fc;
    logic [15:0] d1, d2;
    logic        v1, v2;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [15:0] mm [0:255];
    logic [15:0] e1_d, e2_d, p_d;
    logic        e1_v, e2_v, p_v;
    logic        bact;
    int          cnt;

    always #5 clk = ~clk;

    ram_io_responder #(.DEPTH(256), .READ_LATENCY(1)) u_l1 (
        .UserCLK(clk), .Reset(rst), .FAB2RAM_D(fd), .FAB2RAM_A(fa),
        .FAB2RAM_C(fc), .RAM2FAB_D(d1), .rd_valid(v1));

    ram_io_responder #(.DEPTH(256), .READ_LATENCY(2)) u_l2 (
        .UserCLK(clk), .Reset(rst), .FAB2RAM_D(fd), .FAB2RAM_A(fa),
        .FAB2RAM_C(fc), .RAM2FAB_D(d2), .rd_valid(v2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        e1_d = 16'h0; e1_v = 1'b0;
        e2_d = 16'h0; e2_v = 1'b0;
        p_d  = 16'h0; p_v  = 1'b0;
        bact = 1'b0;  cnt  = 0;
    endtask

    // one rising edge of the spec's behaviour, using the currently driven inputs
    task automatic model_edge();
        int          ea;
        logic        ce, rd;
        logic [15:0] rv;
        if (rst) begin
            model_clear();
            return;
        end
        ce = fc[2];
        ea = int'(fa);
`ifdef RAM_IO_RESPONDER_BURST_EN
        if (ce && fc[3]) begin
            if (bact) ea = cnt;
            bact = 1'b1;
            cnt  = (fc[0] || fc[1]) ? (ea + 1) % 256 : ea;
        end else begin
            bact = 1'b0;
        end
`endif
        rd = ce && fc[1];
        rv = mm[ea];
        e2_v = p_v;
        if (p_v) e2_d = p_d;
        p_v = rd;
        if (rd) p_d = rv;
        e1_v = rd;
        if (rd) e1_d = rv;
        if (ce && fc[0]) mm[ea] = fd;
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".d1"}, 32'(d1), 32'(e1_d));
        chk({tag, ".v1"}, 32'(v1), 32'(e1_v));
        chk({tag, ".d2"}, 32'(d2), 32'(e2_d));
        chk({tag, ".v2"}, 32'(v2), 32'(e2_v));
    endtask

    // drive one cycle of command, clock it, then compare 1ns after the edge
    task automatic step(input string tag, input logic ce, input logic we, input logic re,
                        input logic bu, input logic [7:0] a, input logic [15:0] d);
        fc = {bu, ce, re, we};
        fa = a;
        fd = d;
        @(posedge clk);
        model_edge();
        #1;
        cmp_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    initial begin
        rst = 1'b1;
        fd = 16'h0; fa = 8'h0; fc = 4'h0;
        model_clear();
        #7;
        cmp_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // fill every word so no read ever touches unwritten memory
        for (int i = 0; i < 256; i++) step("fill", 1, 1, 0, 0, 8'(i), 16'(i));

        // write then read, value holds through idle cycles
        step("wr10", 1, 1, 0, 0, 8'h10, 16'hA5A5);
        step("rd10", 1, 0, 1, 0, 8'h10, 16'h0000);
        chk("rd10_val", 32'(d1), 32'h0000_A5A5);
        chk("rd10_vld", 32'(v1), 32'd1);
        for (int i = 0; i < 3; i++) idle("hold");
        chk("hold_val", 32'(d1), 32'h0000_A5A5);
        chk("hold_vld", 32'(v1), 32'd0);

        // collision: read-before-write, then CE=0 gating
        step("wr20", 1, 1, 0, 0, 8'h20, 16'h1111);
        step("wrrd20", 1, 1, 1, 0, 8'h20, 16'h2222);
        chk("coll_old", 32'(d1), 32'h0000_1111);
        step("rd20", 1, 0, 1, 0, 8'h20, 16'h0000);
        chk("coll_new", 32'(d1), 32'h0000_2222);
        step("ce0wr", 0, 1, 0, 0, 8'h20, 16'hFFFF);
        step("rd20b", 1, 0, 1, 0, 8'h20, 16'h0000);
        chk("ce0_gate", 32'(d1), 32'h0000_2222);
        idle("idle");

        // async reset mid-cycle while output shows BEEF
        step("wr30", 1, 1, 0, 0, 8'h30, 16'hBEEF);
        step("rd30", 1, 0, 1, 0, 8'h30, 16'h0000);
        idle("beef");
        chk("beef_pre", 32'(d1), 32'h0000_BEEF);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        cmp_all("async_rst");
        chk("async_rst_d1", 32'(d1), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // pipelined reads of 0,1,2
        step("p0", 1, 0, 1, 0, 8'h00, 16'h0);
        step("p1", 1, 0, 1, 0, 8'h01, 16'h0);
        chk("pipe_l2_d0", 32'(d2), 32'h0);
        chk("pipe_l2_v0", 32'(v2), 32'd1);
        step("p2", 1, 0, 1, 0, 8'h02, 16'h0);
        chk("pipe_l2_d1", 32'(d2), 32'h1);
        idle("p_drain");
        chk("pipe_l2_d2", 32'(d2), 32'h2);
        chk("pipe_l2_v2", 32'(v2), 32'd1);
        idle("p_done");

        // reset with a read in flight drops the pending result
        step("r0", 1, 0, 1, 0, 8'h00, 16'h0);
        step("r1", 1, 0, 1, 0, 8'h01, 16'h0);
        rst = 1'b1;
        #1;
        model_clear();
        cmp_all("flight_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle("post_rst");
            chk("no_pulse_l2", 32'(v2), 32'd0);
        end

        // burst write at FE with wrap, then burst read
        step("bw1", 1, 1, 0, 1, 8'hFE, 16'd1);
        step("bw2", 1, 1, 0, 1, 8'hFE, 16'd2);
        step("bw3", 1, 1, 0, 1, 8'hFE, 16'd3);
        idle("bw_end");
        step("br1", 1, 0, 1, 1, 8'hFE, 16'd0);
        step("br2", 1, 0, 1, 1, 8'hFE, 16'd0);
        step("br3", 1, 0, 1, 1, 8'hFE, 16'd0);
        idle("br_end");
        step("chkFE", 1, 0, 1, 0, 8'hFE, 16'd0);
`ifdef RAM_IO_RESPONDER_BURST_EN
        chk("burst_FE", 32'(d1), 32'd1);
        step("chkFF", 1, 0, 1, 0, 8'hFF, 16'd0);
        chk("burst_FF", 32'(d1), 32'd2);
        step("chk00", 1, 0, 1, 0, 8'h00, 16'd0);
        chk("burst_00", 32'(d1), 32'd3);
`else
        chk("noburst_FE", 32'(d1), 32'd3);
        step("chkFF", 1, 0, 1, 0, 8'hFF, 16'd0);
        chk("noburst_FF", 32'(d1), 32'h00FF);
`endif
        idle("burst_done");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic ce, we, re, bu;
            ce = ($urandom_range(0, 3) != 0);
            we = $urandom_range(0, 1) != 0;
            re = $urandom_range(0, 1) != 0;
            bu = ($urandom_range(0, 2) != 0);
            step("rand", ce, we, re, bu, 8'($urandom), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
